// File: rtl/axis_snoop_upsizer.sv
// Packs a narrow AXI-Stream byte stream into RATIO-lane words. A tlast input
// closes the current word early, with a contiguous low-lane tkeep.
module axis_snoop_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  input  logic [IN_WIDTH-1:0]       s_axis_tdata,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [IN_WIDTH*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]          m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int IDX_W     = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  // The final lane never needs storage: the beat that fills it completes the word.
  logic [RATIO-2:0][IN_WIDTH-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [OUT_WIDTH-1:0]           out_data_q, out_data_d;
  logic [RATIO-1:0]               out_keep_q, out_keep_d;
  logic                           out_last_q, out_last_d;
  logic                           out_valid_q, out_valid_d;

  logic                           accept;
  logic                           complete;
  logic [OUT_WIDTH-1:0]           word;
  logic [RATIO-1:0]               keep;

  assign s_axis_tready = !axis_areset && (!out_valid_q || m_axis_tready);

  // Word closed by the current beat: stored lanes below idx, the live byte in
  // lane idx, zeros above.
  // NOTE: every always_comb output gets a default before any branch so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    word = '0;
    keep = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (IDX_W'(k) < idx_q) begin
        word[k*IN_WIDTH +: IN_WIDTH] = acc_q[k];
      end
    end
    for (int k = 0; k < RATIO; k++) begin
      if (IDX_W'(k) == idx_q) begin
        word[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
      end
      keep[k] = (IDX_W'(k) <= idx_q);
    end
  end

  always_comb begin
    accept      = s_axis_tvalid && s_axis_tready;
    complete    = accept && (s_axis_tlast || (idx_q == LAST_IDX));
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && m_axis_tready) begin
      out_valid_d = 1'b0;
    end

    // A completion can only coincide with an empty or draining output
    // register, so reloading here never overwrites an unaccepted word.
    if (complete) begin
      out_data_d  = word;
      out_keep_d  = keep;
      out_last_d  = s_axis_tlast;
      out_valid_d = 1'b1;
      idx_d       = '0;
      acc_d       = '0;
    end else if (accept) begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (IDX_W'(k) == idx_q) begin
          acc_d[k] = s_axis_tdata;
        end
      end
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its _d input regardless of process ordering.
  // NOTE: the accumulator is a handful of flops, not a RAM, so it is reset
  // along with everything else; a reset mid-packet then leaves no stale bytes.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      acc_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;

endmodule
